tribus_arbiter: RTL and testbench

Round-robin arbiter that owns the output-enables of N tristate buffers driving one shared bus. It grants at most one requester at a time and bounds how long any owner holds the bus when others are waiting. Between owners it inserts a guaranteed all-off turnaround so two drivers never overlap. It sits between the requesting blocks and their per-source tristate buffers; each `gnt[i]` drives buffer `i`'s `en` directly.

---
 rtl/tribus_arbiter.sv | 132 +++++++++++++
 tb/tb_tribus_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tribus_arbiter.sv
// Round-robin owner of N tristate output-enables on one shared bus.
// Bounds bus hold time under contention and forces an all-off turnaround between owners.
module tribus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int TA       = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 preempt
);

    localparam int         IW        = $clog2(N);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [3:0] TA_LAST   = 4'(TA - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] last;
    logic [IW-1:0] last_nx;
    logic [IW-1:0] owner_nx;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic [7:0]    hold_cnt;
    logic [7:0]    hold_nx;
    logic [3:0]    ta_cnt;
    logic [3:0]    ta_nx;
    logic [N-1:0]  gnt_nx;
    logic          busy_nx;
    logic          preempt_nx;
    logic          others_pending;

    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return IW'(sum % N);
    endfunction

    // Scanning from the farthest offset down lets the nearest requester after 'last' win.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[rr_index(last, k)]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_index(last, k);
            end
        end
    end

    assign others_pending = |(req & ~gnt);

    always_comb begin
        state_nx   = state;
        last_nx    = last;
        owner_nx   = owner;
        hold_nx    = hold_cnt;
        ta_nx      = ta_cnt;
        gnt_nx     = gnt;
        busy_nx    = busy;
        preempt_nx = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nx         = OWN;
                    gnt_nx           = '0;
                    gnt_nx[pick_idx] = 1'b1;
                    owner_nx         = pick_idx;
                    busy_nx          = 1'b1;
                    last_nx          = pick_idx;
                    hold_nx          = '0;
                end
            end
            OWN: begin
                // A release with the owner still requesting can only be the forced one.
                if (!req[owner] || (hold_cnt == HOLD_LAST && others_pending)) begin
                    state_nx   = TURN;
                    gnt_nx     = '0;
                    busy_nx    = 1'b0;
                    owner_nx   = '0;
                    ta_nx      = '0;
                    preempt_nx = req[owner];
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end
            TURN: begin
                if (ta_cnt == TA_LAST) begin
                    state_nx = IDLE;
                end else begin
                    ta_nx = ta_cnt + 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= IW'(N - 1);
            owner    <= '0;
            hold_cnt <= '0;
            ta_cnt   <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nx;
            last     <= last_nx;
            owner    <= owner_nx;
            hold_cnt <= hold_nx;
            ta_cnt   <= ta_nx;
            gnt      <= gnt_nx;
            busy     <= busy_nx;
            preempt  <= preempt_nx;
        end
    end

endmodule

// File: tb/tb_tribus_arbiter.sv
// Scoreboard bench for tribus_arbiter: a behavioural model queues expected outputs per edge,
// plus directed grant patterns and bus-safety invariants.
module tb_tribus_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int TA       = 1;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   owner;
    logic         busy;
    logic         preempt;

    tribus_arbiter #(
        .N(N),
        .MAX_HOLD(MAX_HOLD),
        .TA(TA)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .gnt(gnt),
        .owner(owner),
        .busy(busy),
        .preempt(preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [1:0]   owner;
        logic         busy;
        logic         preempt;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: 0 idle, 1 owned, 2 turnaround
    int         m_state;
    logic [1:0] m_last;
    logic [1:0] m_owner;
    int         m_hold;
    int         m_ta;
    logic [3:0] m_gnt;
    logic       m_busy;
    logic       m_pre;

    logic [N-1:0] prev_gnt;
    int           zero_run;
    bit           seen_owner;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_state = 0;
        m_last  = 2'(N - 1);
        m_owner = '0;
        m_hold  = 0;
        m_ta    = 0;
        m_gnt   = '0;
        m_busy  = 1'b0;
        m_pre   = 1'b0;
    endtask

    task automatic modelRelease();
        m_state = 2;
        m_gnt   = '0;
        m_busy  = 1'b0;
        m_owner = '0;
        m_ta    = 0;
    endtask

    task automatic modelEdge(input logic [N-1:0] r);
        int  idx;
        bit  found;
        m_pre = 1'b0;
        case (m_state)
            0: begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    idx = (int'(m_last) + k) % N;
                    if (!found && r[idx]) begin
                        found   = 1'b1;
                        m_state = 1;
                        m_owner = 2'(idx);
                        m_last  = 2'(idx);
                        m_gnt   = 4'b0001 << idx;
                        m_busy  = 1'b1;
                        m_hold  = 0;
                    end
                end
            end
            1: begin
                if (!r[m_owner]) begin
                    modelRelease();
                end else if (m_hold == MAX_HOLD - 1 && (r & ~m_gnt) != 0) begin
                    modelRelease();
                    m_pre = 1'b1;
                end else if (m_hold < MAX_HOLD - 1) begin
                    m_hold++;
                end
            end
            default: begin
                if (m_ta == TA - 1) m_state = 0;
                else m_ta++;
            end
        endcase
    endtask

    task automatic doReset();
        req   = '0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_owner", owner, 0);
        checkOutput("rst_preempt", preempt, 0);
        modelReset();
        prev_gnt   = '0;
        zero_run   = 0;
        seen_owner = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] r);
        exp_t e;
        @(negedge clk);
        req = r;
        modelEdge(r);
        exp_q.push_back('{gnt: m_gnt, owner: m_owner, busy: m_busy, preempt: m_pre});
        @(posedge clk);
        #1;
        checkOutput("sb_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("sb_gnt", gnt, e.gnt);
            checkOutput("sb_owner", owner, e.owner);
            checkOutput("sb_busy", busy, e.busy);
            checkOutput("sb_preempt", preempt, e.preempt);
        end
        checkOutput("onehot", $onehot0(gnt), 1);
        checkOutput("busy_vs_gnt", busy, gnt != 0);
        if (gnt != 0 && prev_gnt != 0) checkOutput("no_switch", gnt, prev_gnt);
        if (gnt != 0 && prev_gnt == 0 && seen_owner) checkOutput("gap_min", zero_run >= TA + 1, 1);
        if (gnt == 0) begin
            zero_run++;
        end else begin
            zero_run   = 0;
            seen_owner = 1'b1;
        end
        prev_gnt = gnt;
    endtask

    initial begin
        int           held;
        int           pulses;
        logic [N-1:0] cur;
        logic [N-1:0] want;

        doReset();

        // Lone owner keeps the bus well past MAX_HOLD without a preempt
        held   = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b0010);
            if (gnt == 4'b0010) held++;
            if (preempt) pulses++;
        end
        checkOutput("single_held", held, 20);
        checkOutput("single_preempt", pulses, 0);
        applyStimulus(4'b0000);
        checkOutput("single_release", gnt, 4'b0000);
        applyStimulus(4'b0000);
        applyStimulus(4'b0000);

        // Forced release ping-pong between sources 0 and 1
        doReset();
        for (int i = 0; i < 21; i++) begin
            applyStimulus(4'b0011);
            want = (i < 8) ? 4'b0001 : (i < 10) ? 4'b0000 : (i < 18) ? 4'b0010 : (i < 20) ? 4'b0000 : 4'b0001;
            checkOutput("forced_gnt", gnt, want);
            checkOutput("forced_preempt", preempt, (i == 8 || i == 18));
        end

        // Round-robin wrap from source 3 back to source 0
        doReset();
        for (int i = 0; i < 21; i++) begin
            applyStimulus(4'b1001);
            want = (i < 8) ? 4'b0001 : (i < 10) ? 4'b0000 : (i < 18) ? 4'b1000 : (i < 20) ? 4'b0000 : 4'b0001;
            checkOutput("wrap_gnt", gnt, want);
        end

        // Owner drops its request on the same edge the hold limit is reached
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(4'b0111);
        checkOutput("simul_owned", gnt, 4'b0001);
        applyStimulus(4'b0110);
        checkOutput("simul_gnt", gnt, 4'b0000);
        checkOutput("simul_preempt", preempt, 0);
        applyStimulus(4'b0110);
        applyStimulus(4'b0110);
        checkOutput("simul_next", gnt, 4'b0010);

        // Asynchronous reset while an owner holds the bus
        doReset();
        applyStimulus(4'b0100);
        checkOutput("midown_gnt", gnt, 4'b0100);
        applyStimulus(4'b0100);
        doReset();
        applyStimulus(4'b0001);
        checkOutput("post_reset_gnt", gnt, 4'b0001);

        // Random contention with slowly changing request patterns
        cur = '0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) cur = 4'($urandom_range(0, 15));
            applyStimulus(cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
